i2s_sdma_ctrl: RTL and testbench

I2S_SDMA_CTRL -- requirements
Module: i2s_sdma_ctrl

---
 rtl/i2s_slave_pkg.sv | 27 ++
 rtl/sdma_tmo_cnt.sv | 43 ++++
 rtl/i2s_sdma_ctrl.sv | 150 +++++++++++++++
 tb/tb_i2s_sdma_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_slave_pkg.sv
// ----------------------------------------------------------------------------
// i2s_slave_pkg
// Shared definitions for the I2S slave SDMA request logic: default parameter
// values, the request controller state encoding and the wait-counter width
// helper.
// ----------------------------------------------------------------------------
package i2s_slave_pkg;

   localparam int unsigned DefLvlW   = 9;
   localparam int unsigned DefTmoCyc = 1023;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StReq   = 3'd1,
      StXfer  = 3'd2,
      StCplt  = 3'd3,
      StErr   = 3'd4
   } sdma_state_e;

   // Bits needed to hold the values 0..max_val.
   function automatic int unsigned tmo_cnt_w(input int unsigned max_val);
      int unsigned w;
      w = $clog2(max_val + 1);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/sdma_tmo_cnt.sv
// ----------------------------------------------------------------------------
// sdma_tmo_cnt
// Saturating wait counter for the SDMA request phase.
//   WB_CLK   : clock (rising edge)
//   WB_RST_n : asynchronous active-low reset
//   i_clr    : synchronous clear, has priority over i_en
//   i_en     : count enable
//   o_tc     : terminal count; high while enabled in the cycle at whose end
//              the count reaches TMO_CYC
// ----------------------------------------------------------------------------
module sdma_tmo_cnt
   import i2s_slave_pkg::*;
#(
   parameter int unsigned TMO_CYC = DefTmoCyc
) (
   input  logic WB_CLK,
   input  logic WB_RST_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int unsigned     CntW    = tmo_cnt_w(TMO_CYC);
   localparam logic [CntW-1:0] CntMax  = CntW'(TMO_CYC);
   localparam logic [CntW-1:0] CntLast = CntW'(TMO_CYC - 1);

   logic [CntW-1:0] r_cnt;

   always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
      if (!WB_RST_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != CntMax)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Flag one cycle early so the state change lands on the edge where the
   // count reaches TMO_CYC; stays high once saturated.
   assign o_tc = i_en && !i_clr && (r_cnt >= CntLast);

endmodule

// File: rtl/i2s_sdma_ctrl.sv
// ----------------------------------------------------------------------------
// i2s_sdma_ctrl
// SDMA request controller for the I2S slave RX FIFO. Issues a burst request
// when the FIFO level meets the threshold, or a single request when a flush
// is pending on a partial FIFO, then tracks the transfer to completion.
//   WB_CLK, WB_RST_n      : clock, asynchronous active-low reset
//   Enable_i              : DMA service enable
//   Flush_i               : drain request for a partial FIFO (level-sensitive)
//   Thresh_i              : burst threshold in words (0 = never)
//   Fifo_Level_i          : RX FIFO fill level
//   SDMA_Active_i         : SDMA channel has accepted the request
//   SDMA_Done_i           : transfer-complete pulse
//   Intr_Clr_i            : clears both sticky interrupts
//   SDMA_Req_o/Sreq_o     : registered burst / single request
//   DMA_Intr_o/Tmo_Intr_o : sticky completion / timeout interrupts
//   Busy_o                : controller not idle
//   Xfer_Cnt_o            : completed transfer count (wraps)
// ----------------------------------------------------------------------------
module i2s_sdma_ctrl
   import i2s_slave_pkg::*;
#(
   parameter int unsigned LVL_W   = DefLvlW,
   parameter int unsigned TMO_CYC = DefTmoCyc
) (
   input  logic             WB_CLK,
   input  logic             WB_RST_n,
   input  logic             Enable_i,
   input  logic             Flush_i,
   input  logic [LVL_W-1:0] Thresh_i,
   input  logic [LVL_W:0]   Fifo_Level_i,
   input  logic             SDMA_Active_i,
   input  logic             SDMA_Done_i,
   input  logic             Intr_Clr_i,
   output logic             SDMA_Req_o,
   output logic             SDMA_Sreq_o,
   output logic             DMA_Intr_o,
   output logic             Tmo_Intr_o,
   output logic             Busy_o,
   output logic [15:0]      Xfer_Cnt_o
);

   sdma_state_e r_state, w_state_nxt;
   logic        r_burst, w_burst_nxt;
   logic        r_burst_hit, r_flush_hit;
   logic        r_req, r_sreq;
   logic        r_done_pend;
   logic        r_dma_intr, r_tmo_intr;
   logic [15:0] r_xfer_cnt;
   logic        w_burst_hit, w_flush_hit;
   logic        w_tmo_tc;

   // Trigger conditions are registered first; together with the registered
   // request this gives the two-cycle request latency.
   assign w_burst_hit = Enable_i && (Thresh_i != '0) && (Fifo_Level_i >= {1'b0, Thresh_i});
   assign w_flush_hit = Enable_i && Flush_i && (Fifo_Level_i != '0);

   sdma_tmo_cnt #(
      .TMO_CYC (TMO_CYC)
   ) u_tmo_cnt (
      .WB_CLK   (WB_CLK),
      .WB_RST_n (WB_RST_n),
      .i_clr    (r_state != StReq),
      .i_en     (r_state == StReq),
      .o_tc     (w_tmo_tc)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_burst_nxt = r_burst;
      case (r_state)
         StIdle: begin
            if (Enable_i && r_burst_hit) begin
               w_state_nxt = StReq;
               w_burst_nxt = 1'b1;
            end else if (Enable_i && r_flush_hit) begin
               w_state_nxt = StReq;
               w_burst_nxt = 1'b0;
            end
         end
         StReq: begin
            // Disable is checked ahead of the timeout so it wins a tie.
            if (SDMA_Active_i) begin
               w_state_nxt = StXfer;
            end else if (!Enable_i) begin
               w_state_nxt = StIdle;
            end else if (w_tmo_tc) begin
               w_state_nxt = StErr;
            end
         end
         StXfer: begin
            if (SDMA_Done_i || r_done_pend) begin
               w_state_nxt = StCplt;
            end
         end
         StCplt:  w_state_nxt = StIdle;
         StErr:   w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
      if (!WB_RST_n) begin
         r_state     <= StIdle;
         r_burst     <= 1'b0;
         r_burst_hit <= 1'b0;
         r_flush_hit <= 1'b0;
         r_req       <= 1'b0;
         r_sreq      <= 1'b0;
         r_done_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_burst     <= w_burst_nxt;
         r_burst_hit <= w_burst_hit;
         r_flush_hit <= w_flush_hit;
         r_req       <= (w_state_nxt == StReq) && w_burst_nxt;
         r_sreq      <= (w_state_nxt == StReq) && !w_burst_nxt;
         // Done arriving on the same edge as Active would otherwise be lost.
         r_done_pend <= (r_state == StReq) && SDMA_Active_i && SDMA_Done_i;
      end
   end

   // Setting has priority over Intr_Clr_i.
   always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
      if (!WB_RST_n) begin
         r_dma_intr <= 1'b0;
         r_tmo_intr <= 1'b0;
         r_xfer_cnt <= '0;
      end else begin
         if (r_state == StCplt) begin
            r_dma_intr <= 1'b1;
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
         end else if (Intr_Clr_i) begin
            r_dma_intr <= 1'b0;
         end
         if (r_state == StErr) begin
            r_tmo_intr <= 1'b1;
         end else if (Intr_Clr_i) begin
            r_tmo_intr <= 1'b0;
         end
      end
   end

   assign SDMA_Req_o  = r_req;
   assign SDMA_Sreq_o = r_sreq;
   assign DMA_Intr_o  = r_dma_intr;
   assign Tmo_Intr_o  = r_tmo_intr;
   assign Busy_o      = (r_state != StIdle);
   assign Xfer_Cnt_o  = r_xfer_cnt;

endmodule

// File: tb/tb_i2s_sdma_ctrl.sv
// ----------------------------------------------------------------------------
// tb_i2s_sdma_ctrl
// Directed bench for i2s_sdma_ctrl. Each scenario drives inputs and, in the
// same step, sets the outputs the controller must show in the cycle now
// starting; a compare process checks every output on each falling edge.
// ----------------------------------------------------------------------------
module tb_i2s_sdma_ctrl;

   localparam int unsigned LvlW   = 9;
   localparam int unsigned TmoCyc = 15;

   logic            WB_CLK;
   logic            WB_RST_n;
   logic            Enable_i;
   logic            Flush_i;
   logic [LvlW-1:0] Thresh_i;
   logic [LvlW:0]   Fifo_Level_i;
   logic            SDMA_Active_i;
   logic            SDMA_Done_i;
   logic            Intr_Clr_i;
   logic            SDMA_Req_o;
   logic            SDMA_Sreq_o;
   logic            DMA_Intr_o;
   logic            Tmo_Intr_o;
   logic            Busy_o;
   logic [15:0]     Xfer_Cnt_o;

   i2s_sdma_ctrl #(
      .LVL_W   (LvlW),
      .TMO_CYC (TmoCyc)
   ) dut (
      .WB_CLK        (WB_CLK),
      .WB_RST_n      (WB_RST_n),
      .Enable_i      (Enable_i),
      .Flush_i       (Flush_i),
      .Thresh_i      (Thresh_i),
      .Fifo_Level_i  (Fifo_Level_i),
      .SDMA_Active_i (SDMA_Active_i),
      .SDMA_Done_i   (SDMA_Done_i),
      .Intr_Clr_i    (Intr_Clr_i),
      .SDMA_Req_o    (SDMA_Req_o),
      .SDMA_Sreq_o   (SDMA_Sreq_o),
      .DMA_Intr_o    (DMA_Intr_o),
      .Tmo_Intr_o    (Tmo_Intr_o),
      .Busy_o        (Busy_o),
      .Xfer_Cnt_o    (Xfer_Cnt_o)
   );

   initial WB_CLK = 1'b0;
   always #5 WB_CLK = ~WB_CLK;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   bit          chk_en  = 1'b0;

   // Expected outputs for the current cycle.
   bit          exp_req, exp_sreq, exp_busy, exp_dma, exp_tmo;
   logic [15:0] exp_cnt;

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, req);
      end
   endtask

   always @(negedge WB_CLK) begin
      if (chk_en) begin
         cmp("req",  {15'd0, SDMA_Req_o},  {15'd0, exp_req});
         cmp("sreq", {15'd0, SDMA_Sreq_o}, {15'd0, exp_sreq});
         cmp("busy", {15'd0, Busy_o},      {15'd0, exp_busy});
         cmp("dma",  {15'd0, DMA_Intr_o},  {15'd0, exp_dma});
         cmp("tmo",  {15'd0, Tmo_Intr_o},  {15'd0, exp_tmo});
         cmp("cnt",  Xfer_Cnt_o,           exp_cnt);
      end
   end

   task automatic tick();
      @(posedge WB_CLK);
      #1;
   endtask

   task automatic set_exp(input bit req, input bit sreq, input bit busy);
      exp_req  = req;
      exp_sreq = sreq;
      exp_busy = busy;
   endtask

   // Caller has applied the trigger inputs in the current cycle. The request
   // must appear two cycles later; Active follows after req_cyc request
   // cycles, Done after xfer_cyc transfer cycles (0: Done together with
   // Active).
   task automatic do_xfer(input bit burst, input int req_cyc, input int xfer_cyc,
                          input bit drop_en, input bit clr_at_cplt);
      tick();
      set_exp(1'b0, 1'b0, 1'b0);
      tick();
      set_exp(burst, !burst, 1'b1);
      cmp("req_latency", {15'd0, (burst ? SDMA_Req_o : SDMA_Sreq_o)}, 16'd1);
      for (int i = 1; i < req_cyc; i++) tick();
      SDMA_Active_i = 1'b1;
      Fifo_Level_i  = '0;
      Flush_i       = 1'b0;
      if (xfer_cyc == 0) SDMA_Done_i = 1'b1;
      tick();
      SDMA_Active_i = 1'b0;
      SDMA_Done_i   = 1'b0;
      set_exp(1'b0, 1'b0, 1'b1);
      if (drop_en) Enable_i = 1'b0;
      if (xfer_cyc != 0) begin
         for (int i = 1; i < xfer_cyc; i++) tick();
         SDMA_Done_i = 1'b1;
         tick();
         SDMA_Done_i = 1'b0;
      end else begin
         tick();
      end
      // Completion cycle.
      if (clr_at_cplt) Intr_Clr_i = 1'b1;
      tick();
      Intr_Clr_i = 1'b0;
      set_exp(1'b0, 1'b0, 1'b0);
      exp_cnt = exp_cnt + 16'd1;
      exp_dma = 1'b1;
      Enable_i = 1'b1;
   endtask

   // Burst request with no Active: drop Enable in request cycle drop_at, or
   // let it time out when drop_at is 0.
   task automatic req_only(input int drop_at);
      int last;
      Thresh_i     = 9'd64;
      Fifo_Level_i = 10'd64;
      tick();
      set_exp(1'b0, 1'b0, 1'b0);
      tick();
      set_exp(1'b1, 1'b0, 1'b1);
      Fifo_Level_i = '0;
      last = (drop_at == 0) ? int'(TmoCyc) : drop_at;
      for (int i = 2; i <= last; i++) tick();
      if (drop_at != 0) begin
         Enable_i = 1'b0;
         tick();
         set_exp(1'b0, 1'b0, 1'b0);
         Enable_i = 1'b1;
      end else begin
         tick();
         set_exp(1'b0, 1'b0, 1'b1);
         tick();
         set_exp(1'b0, 1'b0, 1'b0);
         exp_tmo = 1'b1;
      end
   endtask

   task automatic clear_intr();
      Intr_Clr_i = 1'b1;
      tick();
      Intr_Clr_i = 1'b0;
      exp_dma    = 1'b0;
      exp_tmo    = 1'b0;
   endtask

   initial begin
      WB_RST_n      = 1'b1;
      Enable_i      = 1'b0;
      Flush_i       = 1'b0;
      Thresh_i      = '0;
      Fifo_Level_i  = '0;
      SDMA_Active_i = 1'b0;
      SDMA_Done_i   = 1'b0;
      Intr_Clr_i    = 1'b0;
      set_exp(1'b0, 1'b0, 1'b0);
      exp_dma = 1'b0;
      exp_tmo = 1'b0;
      exp_cnt = '0;

      #2 WB_RST_n = 1'b0;
      #1 chk_en = 1'b1;
      cmp("rst_busy", {15'd0, Busy_o}, 16'd0);
      cmp("rst_cnt",  Xfer_Cnt_o,      16'd0);
      repeat (2) tick();
      WB_RST_n = 1'b1;
      tick();

      // Threshold of zero never triggers.
      Enable_i     = 1'b1;
      Fifo_Level_i = 10'd100;
      repeat (4) tick();
      Fifo_Level_i = '0;
      tick();

      // Burst: level ramps up to the threshold.
      Thresh_i = 9'd64;
      for (int l = 0; l < 64; l++) begin
         Fifo_Level_i = 10'(l);
         tick();
      end
      Fifo_Level_i = 10'd64;
      do_xfer(1'b1, 5, 3, 1'b0, 1'b0);
      cmp("burst_cnt",  Xfer_Cnt_o,          16'd1);
      cmp("burst_dma",  {15'd0, DMA_Intr_o}, 16'd1);
      cmp("burst_busy", {15'd0, Busy_o},     16'd0);
      clear_intr();

      // Flush of a partial FIFO: single request only.
      Fifo_Level_i = 10'd10;
      Flush_i      = 1'b1;
      do_xfer(1'b0, 5, 3, 1'b0, 1'b0);
      cmp("flush_cnt", Xfer_Cnt_o,          16'd2);
      cmp("flush_dma", {15'd0, DMA_Intr_o}, 16'd1);
      clear_intr();

      // Timeout.
      req_only(0);
      cmp("tmo_intr", {15'd0, Tmo_Intr_o}, 16'd1);
      cmp("tmo_cnt",  Xfer_Cnt_o,          16'd2);
      clear_intr();

      // Disable in REQ, early and on the timeout cycle.
      req_only(2);
      req_only(int'(TmoCyc));
      cmp("dis_tmo_tie", {15'd0, Tmo_Intr_o}, 16'd0);
      tick();

      // Disable during XFER still completes.
      Fifo_Level_i = 10'd64;
      do_xfer(1'b1, 3, 4, 1'b1, 1'b0);
      cmp("dis_xfer_dma", {15'd0, DMA_Intr_o}, 16'd1);
      cmp("dis_xfer_cnt", Xfer_Cnt_o,          16'd3);

      // Done coinciding with Active.
      Fifo_Level_i = 10'd64;
      do_xfer(1'b1, 2, 0, 1'b0, 1'b0);
      cmp("done_pend_cnt", Xfer_Cnt_o, 16'd4);

      // Reset in the middle of a transfer.
      Fifo_Level_i = 10'd64;
      tick();
      tick();
      set_exp(1'b1, 1'b0, 1'b1);
      SDMA_Active_i = 1'b1;
      Fifo_Level_i  = '0;
      tick();
      SDMA_Active_i = 1'b0;
      set_exp(1'b0, 1'b0, 1'b1);
      #2 WB_RST_n = 1'b0;
      set_exp(1'b0, 1'b0, 1'b0);
      exp_cnt = '0;
      exp_dma = 1'b0;
      #1;
      cmp("arst_busy", {15'd0, Busy_o},     16'd0);
      cmp("arst_cnt",  Xfer_Cnt_o,          16'd0);
      cmp("arst_dma",  {15'd0, DMA_Intr_o}, 16'd0);
      tick();
      WB_RST_n = 1'b1;
      tick();
      // Done and Active in IDLE are ignored.
      SDMA_Done_i   = 1'b1;
      SDMA_Active_i = 1'b1;
      tick();
      SDMA_Done_i   = 1'b0;
      SDMA_Active_i = 1'b0;
      repeat (3) tick();
      cmp("idle_ign_cnt", Xfer_Cnt_o, 16'd0);

      // Counter wrap with a clear coinciding with the completion cycle.
      force dut.r_xfer_cnt = 16'hFFFF;
      #1;
      release dut.r_xfer_cnt;
      exp_cnt = 16'hFFFF;
      tick();
      Fifo_Level_i = 10'd5;
      Flush_i      = 1'b1;
      do_xfer(1'b0, 1, 1, 1'b0, 1'b1);
      cmp("wrap_cnt", Xfer_Cnt_o,          16'd0);
      cmp("wrap_dma", {15'd0, DMA_Intr_o}, 16'd1);
      repeat (2) tick();

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
